lcd_sync_gen: RTL and testbench



---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_axis_cnt.sv | 56 +++++
 rtl/lcd_sync_gen.sv | 101 ++++++++++
 tb/tb_lcd_sync_gen.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared timing constants and helpers for the 480x272 LCD timing generator.
// Defaults describe the 4.3" panel; every timing value is overridable per instance.
package lcd_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned LCD_H_ACTIVE = 480;
    localparam int unsigned LCD_H_FP     = 2;
    localparam int unsigned LCD_H_SYNC   = 41;
    localparam int unsigned LCD_H_BP     = 2;
    localparam int unsigned LCD_V_ACTIVE = 272;
    localparam int unsigned LCD_V_FP     = 2;
    localparam int unsigned LCD_V_SYNC   = 10;
    localparam int unsigned LCD_V_BP     = 2;

    localparam int unsigned LCD_H_TOTAL = LCD_H_SYNC + LCD_H_BP + LCD_H_ACTIVE + LCD_H_FP;
    localparam int unsigned LCD_V_TOTAL = LCD_V_SYNC + LCD_V_BP + LCD_V_ACTIVE + LCD_V_FP;

    // True when c lies in [lo, lo+len); one extra bit keeps lo+len from wrapping at 1024.
    function automatic logic in_span(input logic [COORD_W-1:0] c,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] len);
        return ({1'b0, c} >= {1'b0, lo}) && ({1'b0, c} < ({1'b0, lo} + {1'b0, len}));
    endfunction

endpackage

// File: rtl/lcd_axis_cnt.sv
// One timing axis: counts sync, back porch, active, front porch and wraps.
// LOOKAHEAD selects whether the coordinate outputs describe this cycle or the next one.
module lcd_axis_cnt
    import lcd_pkg::*;
#(
    parameter int unsigned SYNC_LEN   = LCD_H_SYNC,
    parameter int unsigned BP_LEN     = LCD_H_BP,
    parameter int unsigned ACTIVE_LEN = LCD_H_ACTIVE,
    parameter int unsigned FP_LEN     = LCD_H_FP,
    parameter bit          LOOKAHEAD  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [COORD_W-1:0] cnt,
    output logic               sync_flag,
    output logic               active_flag,
    output logic [COORD_W-1:0] offset,
    output logic               coord_valid,
    output logic               wrap
);

    localparam logic [COORD_W-1:0] LAST   = COORD_W'(SYNC_LEN + BP_LEN + ACTIVE_LEN + FP_LEN - 1);
    localparam logic [COORD_W-1:0] START  = COORD_W'(SYNC_LEN + BP_LEN);
    localparam logic [COORD_W-1:0] SYNC_W = COORD_W'(SYNC_LEN);
    localparam logic [COORD_W-1:0] ACT_W  = COORD_W'(ACTIVE_LEN);

    logic [COORD_W-1:0] cnt_q;
    logic [COORD_W-1:0] cnt_d;
    logic [COORD_W-1:0] coord_src;

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt         = cnt_q;
    assign wrap        = inc && (cnt_q == LAST);
    assign sync_flag   = cnt_q < SYNC_W;
    assign active_flag = in_span(cnt_q, START, ACT_W);

    assign coord_src   = LOOKAHEAD ? cnt_d : cnt_q;
    assign coord_valid = in_span(coord_src, START, ACT_W);
    assign offset      = coord_valid ? coord_src - START : '0;

endmodule

// File: rtl/lcd_sync_gen.sv
// Free-running LCD timing generator: registered hs/vs/de, active coordinates and line/frame strobes.
// Define LCD_SYNC_PREFETCH_EN to make coordinates and strobes lead de by one clock.
module lcd_sync_gen
    import lcd_pkg::*;
#(
    parameter int unsigned H_ACTIVE = lcd_pkg::LCD_H_ACTIVE,
    parameter int unsigned H_FP     = lcd_pkg::LCD_H_FP,
    parameter int unsigned H_SYNC   = lcd_pkg::LCD_H_SYNC,
    parameter int unsigned H_BP     = lcd_pkg::LCD_H_BP,
    parameter int unsigned V_ACTIVE = lcd_pkg::LCD_V_ACTIVE,
    parameter int unsigned V_FP     = lcd_pkg::LCD_V_FP,
    parameter int unsigned V_SYNC   = lcd_pkg::LCD_V_SYNC,
    parameter int unsigned V_BP     = lcd_pkg::LCD_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [COORD_W-1:0] active_x,
    output logic [COORD_W-1:0] active_y,
    output logic               line_start,
    output logic               frame_start
);

`ifdef LCD_SYNC_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    logic [COORD_W-1:0] h_cnt_unused, v_cnt_unused;
    logic               v_wrap_unused;
    logic               h_sync, h_active, h_cv, h_wrap;
    logic               v_sync, v_active, v_cv;
    logic [COORD_W-1:0] h_off, v_off;

    lcd_axis_cnt #(
        .SYNC_LEN(H_SYNC), .BP_LEN(H_BP), .ACTIVE_LEN(H_ACTIVE), .FP_LEN(H_FP), .LOOKAHEAD(PREFETCH)
    ) u_h_axis (
        .clk(clk), .rst(rst), .inc(1'b1),
        .cnt(h_cnt_unused), .sync_flag(h_sync), .active_flag(h_active),
        .offset(h_off), .coord_valid(h_cv), .wrap(h_wrap)
    );

    // Vertical axis advances only on the horizontal wrap, so vs changes at h_cnt = 0.
    lcd_axis_cnt #(
        .SYNC_LEN(V_SYNC), .BP_LEN(V_BP), .ACTIVE_LEN(V_ACTIVE), .FP_LEN(V_FP), .LOOKAHEAD(PREFETCH)
    ) u_v_axis (
        .clk(clk), .rst(rst), .inc(h_wrap),
        .cnt(v_cnt_unused), .sync_flag(v_sync), .active_flag(v_active),
        .offset(v_off), .coord_valid(v_cv), .wrap(v_wrap_unused)
    );

    logic               hs_q, vs_q, de_q, ls_q, fs_q;
    logic               hs_d, vs_d, de_d, ls_d, fs_d;
    logic [COORD_W-1:0] x_q, y_q, x_d, y_d;
    logic               coord_raw;

    always_comb begin
        coord_raw = h_cv && v_cv;
        hs_d      = h_sync ? HS_POL : ~HS_POL;
        vs_d      = v_sync ? VS_POL : ~VS_POL;
        de_d      = h_active && v_active;
        x_d       = coord_raw ? h_off : '0;
        y_d       = coord_raw ? v_off : '0;
        ls_d      = coord_raw && (h_off == '0);
        fs_d      = ls_d && (v_off == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            de_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            x_q  <= x_d;
            y_q  <= y_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign active_x    = x_q;
    assign active_y    = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_sync_gen.sv
// Directed bench for lcd_sync_gen: default 480x272 timing plus a tiny active-high-sync instance.
// Coordinate expectations shift by one clock when LCD_SYNC_PREFETCH_EN is defined.
module tb_lcd_sync_gen;

`ifdef LCD_SYNC_PREFETCH_EN
    localparam int LEAD = 1;
`else
    localparam int LEAD = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hs, vs, de, line_start, frame_start;
    logic [9:0] active_x, active_y;
    logic       p_hs, p_vs, p_de, p_line_start, p_frame_start;
    logic [9:0] p_active_x, p_active_y;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    lcd_sync_gen dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .de(de),
        .active_x(active_x), .active_y(active_y),
        .line_start(line_start), .frame_start(frame_start)
    );

    // H total 10 (3/2/4/1), V total 7 (2/1/3/1), frame = 70 clocks, active-high syncs.
    lcd_sync_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_p (
        .clk(clk), .rst(rst), .hs(p_hs), .vs(p_vs), .de(p_de),
        .active_x(p_active_x), .active_y(p_active_y),
        .line_start(p_line_start), .frame_start(p_frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) begin
            passed++;
            $display("check %s: observed=%0d expected=%0d", tag, obs, expv);
        end else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Starts just after reset release (sampling at negedges, so edge n precedes sample n).
    task automatic run_from_release(input string tag);
        int hs_low = 0, vs_low = 0, de_hi = 0, ls_cnt = 0, fs_cnt = 0;
        int de_err = 0, x_err = 0, hs_win = 0, ls_win = 0, fs_win = 0;
        int x_exp;
        for (int e = 1; e <= 6342; e++) begin
            @(negedge clk);
            if (!hs) hs_low++;
            if (!vs) vs_low++;
            if (de) de_hi++;
            if (line_start) ls_cnt++;
            if (frame_start) fs_cnt++;
        end
        chk({tag, " pre hs low clocks"}, hs_low, 533);
        chk({tag, " pre vs low clocks"}, vs_low, 5250);
        chk({tag, " pre de high clocks"}, de_hi, 0);
        chk({tag, " pre strobes"}, ls_cnt + fs_cnt, 0);

        @(negedge clk); // edge 6343
        chk({tag, " e6343 de"}, de, 0);
        chk({tag, " e6343 frame_start"}, frame_start, LEAD);
        chk({tag, " e6343 active_x"}, active_x, 0);

        @(negedge clk); // edge 6344
        chk({tag, " e6344 de"}, de, 1);
        chk({tag, " e6344 frame_start"}, frame_start, 1 - LEAD);
        chk({tag, " e6344 line_start"}, line_start, 1 - LEAD);
        chk({tag, " e6344 active_x"}, active_x, LEAD);
        chk({tag, " e6344 active_y"}, active_y, 0);

        for (int i = 0; i < 525; i++) begin
            if (i > 0) @(negedge clk);
            if (LEAD == 1) x_exp = (i < 479) ? i + 1 : 0;
            else           x_exp = (i < 480) ? i : 0;
            if (de !== (i < 480)) de_err++;
            if (active_x !== 10'(x_exp)) x_err++;
            if (!hs) hs_win++;
            if (line_start) ls_win++;
            if (frame_start) fs_win++;
        end
        chk({tag, " line de pattern errors"}, de_err, 0);
        chk({tag, " line active_x errors"}, x_err, 0);
        chk({tag, " line hs low clocks"}, hs_win, 41);
        chk({tag, " line line_start pulses"}, ls_win, 1);
        chk({tag, " line frame_start pulses"}, fs_win, 1 - LEAD);
    endtask

    initial begin
        int ph = 0, pv = 0, pd = 0, pf = 0, f_first = 0, f_second = 0;

        #2 rst = 1'b1;
        #2;
        chk("reset hs", hs, 1);
        chk("reset vs", vs, 1);
        chk("reset de", de, 0);
        chk("reset active_x", active_x, 0);
        chk("reset active_y", active_y, 0);
        chk("reset strobes", {line_start, frame_start}, 0);
        chk("reset pol hs", p_hs, 0);
        chk("reset pol vs", p_vs, 0);

        @(negedge clk);
        rst = 1'b0;
        run_from_release("first");

        // Now after edge 6868; 201 more edges lands on line y=1, active_x=200.
        repeat (201) @(negedge clk);
        chk("midline de", de, 1);
        chk("midline active_x", active_x, 200 + LEAD);
        chk("midline active_y", active_y, 1);

        rst = 1'b1;
        #1;
        chk("async hs", hs, 1);
        chk("async vs", vs, 1);
        chk("async de", de, 0);
        chk("async active_x", active_x, 0);
        chk("async active_y", active_y, 0);
        chk("async strobes", {line_start, frame_start}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_from_release("rerun");

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 140; e++) begin
            @(negedge clk);
            if (p_hs) ph++;
            if (p_vs) pv++;
            if (p_de) pd++;
            if (p_frame_start) begin
                pf++;
                if (f_first == 0) f_first = e;
                else f_second = e;
            end
        end
        chk("pol hs high clocks", ph, 42);
        chk("pol vs high clocks", pv, 40);
        chk("pol de high clocks", pd, 24);
        chk("pol frame_start count", pf, 2);
        chk("pol first frame_start edge", f_first, 36 - LEAD);
        chk("pol frame period", f_second - f_first, 70);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
